// File: rtl/riscv_rf_wb_pkg.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_pkg
// Shared types and constants for the register-file writeback scheduler.
//   MAX_WB_REQ : upper bound on the number of writeback requesters
//   WB_ADDR_W  : register address width carried in the structs
//   WB_DATA_W  : register data width carried in the structs
//   WB_PTR_W   : width of the round-robin pointer
//   wb_req_t   : one requester's {addr, data}
//   wb_port_t  : one register-file write port {we, addr, data}
// The scheduler's ADDR_WIDTH/DATA_WIDTH parameters default to WB_ADDR_W and
// WB_DATA_W and must keep those values, because the structs are sized here.
// ----------------------------------------------------------------------------
package riscv_rf_wb_pkg;

   localparam int MAX_WB_REQ = 8;
   localparam int WB_ADDR_W  = 5;
   localparam int WB_DATA_W  = 32;
   localparam int WB_PTR_W   = $clog2(MAX_WB_REQ);

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef struct packed {
      logic                 we;
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_port_t;

endpackage

// File: rtl/riscv_rf_wb_scheduler_rr_arb.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_rr_arb
// Round-robin picker over requesters 1..NUM_REQ-1. Returns up to two one-hot
// grants in round-robin order starting at the pointer.
//   i_req        : request mask
//   i_excl       : requesters that may not be granted this cycle
//   i_pair_excl  : [i][j] set when j may not be granted together with i
//   i_ptr        : round-robin start index (1..NUM_REQ-1)
//   i_two        : allow a second grant (both port slots free)
//   o_gnt_first  : higher-priority grant (one-hot or zero)
//   o_gnt_second : lower-priority grant (one-hot or zero)
//   o_any        : at least one grant issued
//   o_next_ptr   : index after the last grant, wrapping to 1
// ----------------------------------------------------------------------------
module riscv_rf_wb_rr_arb
   import riscv_rf_wb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:1]                i_req,
   input  logic [NUM_REQ-1:1]                i_excl,
   input  logic [NUM_REQ-1:1][NUM_REQ-1:1]   i_pair_excl,
   input  logic [WB_PTR_W-1:0]               i_ptr,
   input  logic                              i_two,
   output logic [NUM_REQ-1:1]                o_gnt_first,
   output logic [NUM_REQ-1:1]                o_gnt_second,
   output logic                              o_any,
   output logic [WB_PTR_W-1:0]               o_next_ptr
);

   logic [NUM_REQ-1:1] w_cand;
   logic               w_have1;
   logic               w_have2;
   int                 w_first;
   int                 w_last;
   int                 w_pos;

   always_comb begin
      o_gnt_first  = '0;
      o_gnt_second = '0;
      o_any        = 1'b0;
      o_next_ptr   = i_ptr;
      w_cand       = i_req & ~i_excl;
      w_have1      = 1'b0;
      w_have2      = 1'b0;
      w_first      = 1;
      w_last       = 1;
      w_pos        = 1;
      // Visit positions in round-robin order: ptr, ptr+1, ... wrapping 1..NUM_REQ-1.
      for (int k = 0; k < NUM_REQ-1; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos > NUM_REQ-1) w_pos = w_pos - (NUM_REQ-1);
         for (int j = 1; j < NUM_REQ; j++) begin
            if (j == w_pos && w_cand[j]) begin
               if (!w_have1) begin
                  w_have1        = 1'b1;
                  w_first        = j;
                  w_last         = j;
                  o_gnt_first[j] = 1'b1;
               end else if (i_two && !w_have2 && !i_pair_excl[w_first][j]) begin
                  // A same-address partner of the first grant is skipped; a
                  // later non-conflicting requester may still take the slot.
                  w_have2         = 1'b1;
                  w_last          = j;
                  o_gnt_second[j] = 1'b1;
               end
            end
         end
      end
      o_any = w_have1;
      if (w_have1) begin
         o_next_ptr = (w_last == NUM_REQ-1) ? WB_PTR_W'(1) : WB_PTR_W'(w_last + 1);
      end
   end

endmodule

// File: rtl/riscv_rf_wb_scheduler.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_scheduler
// Writeback scheduler for the 2-write-port integer register file. Arbitrates
// NUM_REQ requesters (index 0 = LSU, fixed top priority; others round-robin)
// onto ports B (first grant, wins inside the file) and A (second grant), and
// keeps a pending-write scoreboard for decode RAW stalls.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i/addr_i/data_i       writeback requests (flattened per requester)
//   req_ready_o                     combinational grants
//   alloc_valid_i/alloc_addr_i      decode reserves a destination register
//   flush_i                         clears the scoreboard
//   raddr_{a,b,c}_i / busy_{a,b,c}_o  scoreboard lookups (combinational)
//   waddr/wdata/we_{a,b}_o          registered register-file write ports
// Optional (macro RF_WB_PERF_CNT_EN):
//   stall_cnt_clr_i / stall_cnt_o   saturating count of cycles with an
//                                   ungranted valid request
// ----------------------------------------------------------------------------
module riscv_rf_wb_scheduler
   import riscv_rf_wb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = WB_ADDR_W,
   parameter int DATA_WIDTH = WB_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          alloc_valid_i,
   input  logic [ADDR_WIDTH-1:0]         alloc_addr_i,
   input  logic                          flush_i,
   input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
   input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
   input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
   output logic                          busy_a_o,
   output logic                          busy_b_o,
   output logic                          busy_c_o,
   output logic [ADDR_WIDTH-1:0]         waddr_a_o,
   output logic [DATA_WIDTH-1:0]         wdata_a_o,
   output logic                          we_a_o,
   output logic [ADDR_WIDTH-1:0]         waddr_b_o,
   output logic [DATA_WIDTH-1:0]         wdata_b_o,
   output logic                          we_b_o
`ifdef RF_WB_PERF_CNT_EN
   ,
   input  logic                          stall_cnt_clr_i,
   output logic [31:0]                   stall_cnt_o
`endif
);

   localparam int NREG = 1 << ADDR_WIDTH;

   wb_req_t                            w_req [NUM_REQ];
   logic [NUM_REQ-1:1]                 w_rr_req;
   logic [NUM_REQ-1:1]                 w_rr_excl;
   logic [NUM_REQ-1:1][NUM_REQ-1:1]    w_pair_excl;
   logic [NUM_REQ-1:1]                 w_gnt_first;
   logic [NUM_REQ-1:1]                 w_gnt_second;
   logic                               w_rr_any;
   logic [WB_PTR_W-1:0]                w_next_ptr;
   wb_req_t                            w_rr_first;
   wb_req_t                            w_rr_second;
   wb_req_t                            w_src_a;
   wb_req_t                            w_src_b;
   logic                               w_gnt_a;
   logic                               w_gnt_b;
   logic [NREG-1:0]                    w_sb_next;

   logic [WB_PTR_W-1:0]                r_rr_ptr;
   wb_port_t                           r_port_a;
   wb_port_t                           r_port_b;
   logic [NREG-1:0]                    r_sb;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req[gi].addr = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_req[gi].data = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Conflict masks: x0 writes never conflict because they are dropped.
   always_comb begin
      w_rr_req    = req_valid_i[NUM_REQ-1:1];
      w_rr_excl   = '0;
      w_pair_excl = '0;
      for (int j = 1; j < NUM_REQ; j++) begin
         w_rr_excl[j] = req_valid_i[0] && (w_req[0].addr != '0) &&
                        (w_req[j].addr == w_req[0].addr);
         for (int i = 1; i < NUM_REQ; i++) begin
            w_pair_excl[i][j] = (i != j) && (w_req[i].addr != '0) &&
                                (w_req[i].addr == w_req[j].addr);
         end
      end
   end

   riscv_rf_wb_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arb (
      .i_req        (w_rr_req),
      .i_excl       (w_rr_excl),
      .i_pair_excl  (w_pair_excl),
      .i_ptr        (r_rr_ptr),
      .i_two        (~req_valid_i[0]),
      .o_gnt_first  (w_gnt_first),
      .o_gnt_second (w_gnt_second),
      .o_any        (w_rr_any),
      .o_next_ptr   (w_next_ptr)
   );

   // Port mapping: highest-priority grant to B, the other to A.
   always_comb begin
      w_rr_first  = '0;
      w_rr_second = '0;
      for (int j = 1; j < NUM_REQ; j++) begin
         if (w_gnt_first[j])  w_rr_first  = w_req[j];
         if (w_gnt_second[j]) w_rr_second = w_req[j];
      end
      if (req_valid_i[0]) begin
         w_src_b = w_req[0];
         w_gnt_b = 1'b1;
         w_src_a = w_rr_first;
         w_gnt_a = |w_gnt_first;
      end else begin
         w_src_b = w_rr_first;
         w_gnt_b = |w_gnt_first;
         w_src_a = w_rr_second;
         w_gnt_a = |w_gnt_second;
      end
   end

   assign req_ready_o = {w_gnt_first | w_gnt_second, req_valid_i[0]};

   // Scoreboard: clear on an active port write, set on alloc (set wins),
   // flush overrides everything, x0 never busy.
   always_comb begin
      w_sb_next = r_sb;
      if (r_port_a.we) w_sb_next[r_port_a.addr] = 1'b0;
      if (r_port_b.we) w_sb_next[r_port_b.addr] = 1'b0;
      if (alloc_valid_i) w_sb_next[alloc_addr_i] = 1'b1;
      if (flush_i) w_sb_next = '0;
      w_sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_port_a <= '0;
         r_port_b <= '0;
         r_rr_ptr <= WB_PTR_W'(1);
         r_sb     <= '0;
      end else begin
         // A grant to x0 still takes its port slot but never writes.
         r_port_a.we <= w_gnt_a && (w_src_a.addr != '0);
         r_port_b.we <= w_gnt_b && (w_src_b.addr != '0);
         if (w_gnt_a) begin
            r_port_a.addr <= w_src_a.addr;
            r_port_a.data <= w_src_a.data;
         end
         if (w_gnt_b) begin
            r_port_b.addr <= w_src_b.addr;
            r_port_b.data <= w_src_b.data;
         end
         if (w_rr_any) r_rr_ptr <= w_next_ptr;
         r_sb <= w_sb_next;
      end
   end

   assign we_a_o    = r_port_a.we;
   assign waddr_a_o = r_port_a.addr;
   assign wdata_a_o = r_port_a.data;
   assign we_b_o    = r_port_b.we;
   assign waddr_b_o = r_port_b.addr;
   assign wdata_b_o = r_port_b.data;

   assign busy_a_o = r_sb[raddr_a_i];
   assign busy_b_o = r_sb[raddr_b_i];
   assign busy_c_o = r_sb[raddr_c_i];

`ifdef RF_WB_PERF_CNT_EN
   logic        w_stall;
   logic [31:0] r_stall_cnt;

   assign w_stall = |(req_valid_i & ~req_ready_o);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall_cnt_clr_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_rf_wb_scheduler.sv
// ----------------------------------------------------------------------------
// tb_riscv_rf_wb_scheduler
// Scoreboard bench: a priority-list reference model predicts grants, port
// writes and busy bits; expected port writes are queued and popped by a
// separate monitor whenever a write enable appears on the DUT.
// ----------------------------------------------------------------------------
module tb_riscv_rf_wb_scheduler;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid_i;
   logic [N*AW-1:0] req_addr_i;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_ready_o;
   logic            alloc_valid_i;
   logic [AW-1:0]   alloc_addr_i;
   logic            flush_i;
   logic [AW-1:0]   raddr_a_i, raddr_b_i, raddr_c_i;
   logic            busy_a_o, busy_b_o, busy_c_o;
   logic [AW-1:0]   waddr_a_o, waddr_b_o;
   logic [DW-1:0]   wdata_a_o, wdata_b_o;
   logic            we_a_o, we_b_o;
`ifdef RF_WB_PERF_CNT_EN
   logic            stall_cnt_clr_i = 1'b0;
   logic [31:0]     stall_cnt_o;
`endif

   always #5 clk = ~clk;

   riscv_rf_wb_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o),
      .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .flush_i(flush_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
      .busy_a_o(busy_a_o), .busy_b_o(busy_b_o), .busy_c_o(busy_c_o),
      .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
      .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o)
`ifdef RF_WB_PERF_CNT_EN
      , .stall_cnt_clr_i(stall_cnt_clr_i), .stall_cnt_o(stall_cnt_o)
`endif
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic          we_a;
      logic [AW-1:0] addr_a;
      logic [DW-1:0] data_a;
      logic          we_b;
      logic [AW-1:0] addr_b;
      logic [DW-1:0] data_b;
   } exp_t;

   // Reference model state
   logic          m_valid [N];
   logic [AW-1:0] m_addr  [N];
   logic [DW-1:0] m_data  [N];
   int            m_ptr;
   logic          m_sb [32];
   logic [AW-1:0] cur_clr[$];
   logic [AW-1:0] nxt_clr[$];
   exp_t          exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
      end
      m_ptr = 1;
      for (int r = 0; r < 32; r++) m_sb[r] = 1'b0;
      cur_clr.delete();
      nxt_clr.delete();
      exp_q.delete();
   endtask

   task automatic apply_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid_i[i]          = m_valid[i];
         req_addr_i[i*AW +: AW]  = m_addr[i];
         req_data_i[i*DW +: DW]  = m_data[i];
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_valid[i] = 1'b1;
      m_addr[i]  = a;
      m_data[i]  = d;
   endtask

   task automatic quiet();
      alloc_valid_i = 1'b0;
      alloc_addr_i  = '0;
      flush_i       = 1'b0;
   endtask

   // Called mid-cycle: predict this cycle's grants and advance model state.
   task automatic model_step();
      int            order[$];
      int            g[$];
      int            last;
      logic [N-1:0]  exp_ready;
      exp_t          e;
      chk("busy_a", busy_a_o, m_sb[raddr_a_i]);
      chk("busy_b", busy_b_o, m_sb[raddr_b_i]);
      chk("busy_c", busy_c_o, m_sb[raddr_c_i]);
      if (m_valid[0]) order.push_back(0);
      for (int k = 0; k < N-1; k++) begin
         int j;
         j = ((m_ptr - 1 + k) % (N-1)) + 1;
         if (m_valid[j]) order.push_back(j);
      end
      foreach (order[o]) begin
         int c;
         c = order[o];
         if (g.size() == 0) g.push_back(c);
         else if (g.size() == 1 && !(m_addr[c] != 0 && m_addr[c] == m_addr[g[0]])) g.push_back(c);
      end
      exp_ready = '0;
      last = 0;
      foreach (g[x]) begin
         exp_ready[g[x]] = 1'b1;
         if (g[x] != 0) last = g[x];
      end
      chk("ready", req_ready_o, exp_ready);
      if (last != 0) m_ptr = (last % (N-1)) + 1;
      e = '0;
      nxt_clr.delete();
      if (g.size() > 0) begin
         e.we_b = (m_addr[g[0]] != 0); e.addr_b = m_addr[g[0]]; e.data_b = m_data[g[0]];
         if (e.we_b) nxt_clr.push_back(e.addr_b);
      end
      if (g.size() > 1) begin
         e.we_a = (m_addr[g[1]] != 0); e.addr_a = m_addr[g[1]]; e.data_a = m_data[g[1]];
         if (e.we_a) nxt_clr.push_back(e.addr_a);
      end
      if (e.we_a || e.we_b) exp_q.push_back(e);
      foreach (g[x]) m_valid[g[x]] = 1'b0;
      if (flush_i) begin
         for (int r = 0; r < 32; r++) m_sb[r] = 1'b0;
      end else begin
         foreach (cur_clr[x]) m_sb[cur_clr[x]] = 1'b0;
         if (alloc_valid_i && alloc_addr_i != 0) m_sb[alloc_addr_i] = 1'b1;
      end
      cur_clr = nxt_clr;
   endtask

   task automatic step();
      apply_reqs();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_cycle();
      for (int i = 0; i < N; i++) begin
         if (!m_valid[i] && $urandom_range(0, 99) < 50)
            set_req(i, AW'($urandom_range(0, 11)), $urandom);
      end
      alloc_valid_i = ($urandom_range(0, 3) == 0);
      alloc_addr_i  = AW'($urandom_range(0, 11));
      flush_i       = ($urandom_range(0, 19) == 0);
      raddr_a_i     = AW'($urandom_range(0, 11));
      raddr_b_i     = AW'($urandom_range(0, 11));
      raddr_c_i     = AW'($urandom_range(0, 11));
   endtask

   // Monitor: every presented write is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (we_a_o || we_b_o)) begin
         if (we_a_o && we_b_o) chk("port_addr_distinct", 64'(waddr_a_o == waddr_b_o), 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {we_a_o, we_b_o}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("we_a", we_a_o, e.we_a);
            chk("we_b", we_b_o, e.we_b);
            if (e.we_a) begin
               chk("waddr_a", waddr_a_o, e.addr_a);
               chk("wdata_a", wdata_a_o, e.data_a);
            end
            if (e.we_b) begin
               chk("waddr_b", waddr_b_o, e.addr_b);
               chk("wdata_b", wdata_b_o, e.data_b);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      model_reset();
      quiet();
      raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
      apply_reqs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we_a", we_a_o, 0);
      chk("rst_we_b", we_b_o, 0);
      chk("rst_waddr_a", waddr_a_o, 0);
      chk("rst_wdata_b", wdata_b_o, 0);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_busy_a", busy_a_o, 0);
      rst_n = 1'b1;

      // Three requesters, pointer at 1: req0+req1 first, req2 next cycle.
      set_req(0, 5'd3, 32'h1); set_req(1, 5'd4, 32'h2); set_req(2, 5'd7, 32'h3);
      apply_reqs(); #1;
      chk("t2_ready_first", req_ready_o, 3'b011);
      step();
      apply_reqs(); #1;
      chk("t2_ready_second", req_ready_o, 3'b100);
      step();

      // Two-port write with fixed port mapping.
      set_req(0, 5'd5, 32'hAA); set_req(1, 5'd6, 32'hBB);
      step();
      chk("t1_we_b", we_b_o, 1); chk("t1_waddr_b", waddr_b_o, 5);  chk("t1_wdata_b", wdata_b_o, 32'hAA);
      chk("t1_we_a", we_a_o, 1); chk("t1_waddr_a", waddr_a_o, 6);  chk("t1_wdata_a", wdata_a_o, 32'hBB);

      // Bring pointer back to 1, then same-address pair.
      set_req(2, 5'd1, 32'h11);
      step();
      set_req(1, 5'd9, 32'h91); set_req(2, 5'd9, 32'h92);
      apply_reqs(); #1;
      chk("t3_ready_first", req_ready_o, 3'b010);
      step();
      apply_reqs(); #1;
      chk("t3_ready_second", req_ready_o, 3'b100);
      step();
      step();

      // Write to x0.
      set_req(0, 5'd0, 32'hFF);
      apply_reqs(); #1;
      chk("x0_ready", req_ready_o, 3'b001);
      step();
      chk("x0_we_a", we_a_o, 0);
      chk("x0_we_b", we_b_o, 0);

      // Busy window around alloc and write of x12.
      raddr_a_i = 5'd12; raddr_b_i = 5'd0;
      alloc_valid_i = 1'b1; alloc_addr_i = 5'd12;
      step();
      quiet();
      chk("t4_busy_after_alloc", busy_a_o, 1);
      step(); step();
      set_req(1, 5'd12, 32'hC12);
      step();
      chk("t4_busy_during_write", busy_a_o, 1);
      step();
      chk("t4_busy_cleared", busy_a_o, 0);

      // Alloc and flush together.
      raddr_b_i = 5'd8;
      alloc_valid_i = 1'b1; alloc_addr_i = 5'd8; flush_i = 1'b1;
      step();
      quiet();
      chk("t5_flush_beats_alloc", busy_b_o, 0);

      for (int c = 0; c < 1500; c++) begin
         randomize_cycle();
         step();
      end
      quiet();
      repeat (6) step();

      // Reset while port B is writing.
      set_req(0, 5'd10, 32'h55);
      step();
      chk("rst_mid_we_b_before", we_b_o, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we_b", we_b_o, 0);
      chk("rst_mid_waddr_b", waddr_b_o, 0);
      model_reset();
      quiet();
      apply_reqs();
      #2;
      rst_n = 1'b1;

      for (int c = 0; c < 300; c++) begin
         randomize_cycle();
         step();
      end
      quiet();
      repeat (6) step();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
